// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: turns an external interrupt request into the pipeline entry
// micro-sequence (freeze, drain, push PC/CCR, fetch vector, load PC) and tracks ISR
// residency until RTI retires. Non-nesting, one request can be held pending.
// Optional feature macro: INT_CCR_PUSH_EN (defined: CCR is pushed after the PC halves).
module interrupt_sequencer #(
  parameter logic [11:0] VECTOR_ADDR  = 12'h000,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic        stall_in,
  input  logic [31:0] pc_in,
  input  logic [2:0]  ccr_in,
  input  logic        rti_done,
  input  logic [15:0] vec_data,
  output logic        freeze_out,
  output logic        push_valid,
  output logic [15:0] push_data,
  output logic [1:0]  push_sel,
  output logic        vec_rd,
  output logic [11:0] vec_addr,
  output logic        pc_load,
  output logic [31:0] pc_load_addr,
  output logic        int_ack,
  output logic        int_active
);

  typedef enum logic [3:0] {
    StIdle,
    StDrain,
    StPushLo,
    StPushHi,
    StPushCcr,
    StVecLo,
    StVecHi,
    StVecWait,
    StJump,
    StInIsr
  } state_e;

  state_e      state;
  logic        pending;
  logic [31:0] saved_pc;
  logic [31:0] vec;
  logic [3:0]  drain_cnt;

`ifdef INT_CCR_PUSH_EN
  logic [2:0]  saved_ccr;
`else
  logic        unused_ccr;
  assign unused_ccr = ^ccr_in;
`endif

  // The vector register is a flop, so the jump target is a registered output.
  assign pc_load_addr = vec;

  // Sequencer: every output is registered, so each branch sets the values for the
  // state it is about to enter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      pending    <= 1'b0;
      saved_pc   <= '0;
      vec        <= '0;
      drain_cnt  <= '0;
`ifdef INT_CCR_PUSH_EN
      saved_ccr  <= '0;
`endif
      freeze_out <= 1'b0;
      push_valid <= 1'b0;
      push_data  <= '0;
      push_sel   <= '0;
      vec_rd     <= 1'b0;
      vec_addr   <= '0;
      pc_load    <= 1'b0;
      int_ack    <= 1'b0;
      int_active <= 1'b0;
    end else begin
      freeze_out <= 1'b0;
      push_valid <= 1'b0;
      push_data  <= '0;
      push_sel   <= '0;
      vec_rd     <= 1'b0;
      vec_addr   <= '0;
      pc_load    <= 1'b0;
      int_ack    <= 1'b0;
      int_active <= 1'b0;
      if (int_req) pending <= 1'b1;

      unique case (state)
        StIdle: begin
          if (pending && !stall_in) begin
            // A fresh request on the accepting edge stays pending.
            pending    <= int_req;
            saved_pc   <= pc_in;
`ifdef INT_CCR_PUSH_EN
            saved_ccr  <= ccr_in;
`endif
            drain_cnt  <= 4'(DRAIN_CYCLES);
            freeze_out <= 1'b1;
            state      <= StDrain;
          end
        end
        StDrain: begin
          freeze_out <= 1'b1;
          drain_cnt  <= drain_cnt - 4'd1;
          if (drain_cnt <= 4'd1) begin
            push_valid <= 1'b1;
            push_sel   <= 2'd0;
            push_data  <= saved_pc[15:0];
            state      <= StPushLo;
          end
        end
        StPushLo: begin
          freeze_out <= 1'b1;
          push_valid <= 1'b1;
          push_sel   <= 2'd1;
          push_data  <= saved_pc[31:16];
          state      <= StPushHi;
        end
        StPushHi: begin
          freeze_out <= 1'b1;
`ifdef INT_CCR_PUSH_EN
          push_valid <= 1'b1;
          push_sel   <= 2'd2;
          push_data  <= {13'b0, saved_ccr};
          state      <= StPushCcr;
`else
          vec_rd     <= 1'b1;
          vec_addr   <= VECTOR_ADDR;
          state      <= StVecLo;
`endif
        end
`ifdef INT_CCR_PUSH_EN
        StPushCcr: begin
          freeze_out <= 1'b1;
          vec_rd     <= 1'b1;
          vec_addr   <= VECTOR_ADDR;
          state      <= StVecLo;
        end
`endif
        StVecLo: begin
          freeze_out <= 1'b1;
          vec_rd     <= 1'b1;
          vec_addr   <= VECTOR_ADDR + 12'd1;
          state      <= StVecHi;
        end
        StVecHi: begin
          freeze_out <= 1'b1;
          vec[15:0]  <= vec_data;
          state      <= StVecWait;
        end
        StVecWait: begin
          freeze_out <= 1'b1;
          vec[31:16] <= vec_data;
          pc_load    <= 1'b1;
          int_ack    <= 1'b1;
          state      <= StJump;
        end
        StJump: begin
          int_active <= 1'b1;
          state      <= StInIsr;
        end
        StInIsr: begin
          if (rti_done) state <= StIdle;
          else          int_active <= 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Upstream companion to the pipelined processor top. Turns the external interrupt request into a fixed micro-sequence that the pipeline carries out:
  - freeze fetch
  - drain in-flight instructions
  - push return PC (two halves) and CCR to the stack
  - read the 32-bit ISR vector from data memory (two 16-bit words)
  - force a PC load
- Tracks ISR residency until RTI retires. Non-nesting. One request can be held pending.

Parameters:
- VECTOR_ADDR, 12'h000: data-memory word address of the vector low half. The high half is at VECTOR_ADDR+1.
- DRAIN_CYCLES, 3: cycles of fetch freeze before the first push. Legal range is 1..15.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- int_req, input, 1: external interrupt request, level or pulse, sampled every edge.
- stall_in, input, 1: pipeline unsafe for entry (branch, call, ret, rti or load-use in flight).
- pc_in, input, 32: PC of the next instruction to resume.
- ccr_in, input, 3: current flags.
- rti_done, input, 1: one-cycle pulse when RTI retires.
- vec_data, input, 16: data-memory read data, valid one cycle after vec_rd.
- freeze_out, output, 1: holds fetch PC and injects NOPs.
- push_valid, output, 1: stack push strobe.
- push_data, output, 16: word to push.
- push_sel, output, 2: push type. 0 = PC low, 1 = PC high, 2 = CCR.
- vec_rd, output, 1: vector memory read strobe.
- vec_addr, output, 12: vector memory address.
- pc_load, output, 1: one-cycle strobe that forces the fetch PC.
- pc_load_addr, output, 32: new fetch PC.
- int_ack, output, 1: one-cycle pulse, coincident with pc_load.
- int_active, output, 1: high while the ISR is executing.

Behaviour:
- Reset: state goes to IDLE; the pending flag, saved PC, saved CCR, vector register and drain counter clear; all outputs are 0. This applies mid-sequence too: the partial sequence is abandoned. An int_req asserted in the reset cycle is ignored.
- Pending flag:
  - Set on any edge where int_req=1.
  - Cleared on the edge that accepts the request.
  - Repeat requests while pending coalesce into one.
- IDLE:
  - If pending=1 and stall_in=0, the edge accepts: capture pc_in and ccr_in, load the drain counter with DRAIN_CYCLES, go to DRAIN.
  - If stall_in=1, remain in IDLE with pending held.
  - int_req=1 with stall_in=0 on the same edge is not accepted until the following edge, because pending is registered.
- DRAIN:
  - freeze_out=1.
  - The counter decrements each cycle; at 1, go to PUSH_LO.
  - stall_in is ignored.
- PUSH_LO: push_valid=1, push_sel=0, push_data=saved_pc[15:0].
- PUSH_HI: push_valid=1, push_sel=1, push_data=saved_pc[31:16].
- PUSH_CCR: push_valid=1, push_sel=2, push_data={13'b0, saved_ccr}.
- VEC_LO: vec_rd=1, vec_addr=VECTOR_ADDR.
- VEC_HI: vec_rd=1, vec_addr=VECTOR_ADDR+1 (12-bit wrap); capture vec_data into vec[15:0].
- VEC_WAIT: capture vec_data into vec[31:16].
- JUMP:
  - pc_load=1, int_ack=1, pc_load_addr=vec (registered).
  - freeze_out remains 1 in this cycle and drops on entry to IN_ISR.
- IN_ISR:
  - int_active=1.
  - new int_req sets pending only.
  - rti_done=1 goes to IDLE.
  - If int_req and rti_done arrive together, pending is set and IDLE then re-enters normally.
- freeze_out=1 in every state from DRAIN through JUMP; push_valid, vec_rd and pc_load are 0 outside their own states.
- rti_done outside IN_ISR is ignored.
- Latency, with the accepting edge as cycle 0 and DRAIN_CYCLES=3: DRAIN occupies cycles 1-3, PUSH_LO 4, PUSH_HI 5, PUSH_CCR 6, VEC_LO 7, VEC_HI 8, VEC_WAIT 9, JUMP 10.

Optional Feature:
- INT_CCR_PUSH_EN
  - Defined: the PUSH_CCR state exists as above, and JUMP occurs at cycle 10.
  - Undefined: the PUSH_CCR state is compiled out, PUSH_HI goes directly to VEC_LO, push_sel never equals 2, JUMP occurs at cycle 9, and ccr_in is unused.

Test Plan:
1. Basic entry and return:
   - Stimulus: int_req pulse with stall_in=0, pc_in=32'h0001_0024, ccr_in=3'b101, memory[0]=16'h0200, memory[1]=16'h0000.
   - Required: pushes 0024, 0001, 0005 on cycles 4-6; pc_load=1 with 32'h0000_0200 on cycle 10; int_active rises; rti_done returns the block to IDLE.
2. Stall deferral:
   - Stimulus: int_req while stall_in=1 for 5 cycles.
   - Required: no freeze_out until the edge after stall_in falls; pending held throughout.
3. Request during ISR:
   - Stimulus: int_req while in IN_ISR, then rti_done.
   - Required: IDLE for one cycle, then re-entry; a second pc_load occurs exactly 11 cycles after rti_done.
4. Simultaneous events:
   - Stimulus: rti_done and int_req on the same edge.
   - Required: pending=1, and the next sequence starts the following cycle.
5. Reset mid-sequence:
   - Stimulus: assert rst in PUSH_HI.
   - Required: next cycle all outputs are 0, state is IDLE, pending=0, and no pc_load is ever issued for the aborted request.
6. Feature compiled out:
   - Stimulus: INT_CCR_PUSH_EN undefined, same stimulus as test 1.
   - Required: exactly two pushes; pc_load on cycle 9.
